// File: rtl/entity_loader_pkg.sv
// entity_loader_pkg
// Shared definitions for the entity loader: descriptor layout, reset
// descriptor, stream framing bit positions and the receive FSM states.
// Configuration macro used by the top level: ENTITY_LOADER_SYNC_EN.
package entity_loader_pkg;

    // Descriptor layout: [13:10] ID, [9:8] orientation, [7:0] tile location
    localparam int ENTITY_W   = 14;
    localparam int ID_LSB     = 10;
    localparam int ORIENT_LSB = 8;
    localparam int TILE_LSB   = 0;
    localparam int ID_W       = 4;

    // ID marking an unused channel; every slot holds this after reset
    localparam logic [ID_W-1:0]     UNUSED_ID  = 4'hF;
    localparam logic [ENTITY_W-1:0] RESET_DESC = {UNUSED_ID, 2'b00, 8'h00};

    // Stream framing
    localparam int HDR_BIT        = 7;
    localparam int CMD_COMMIT_BIT = 6;
    localparam int SLOT_W         = 4;
    localparam int HALF_W         = 7;   // payload bits carried per data byte

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/entity_loader_rx_parser.sv
// entity_rx_parser
// Decodes the framed byte stream into shadow-bank write requests and
// commit requests.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   byte_in, byte_vld   accepted stream byte and its strobe
//   wr_en               one-cycle write request (combinational, same cycle
//                       as the final data byte)
//   wr_slot, wr_data    target slot and assembled descriptor
//   commit_req          commit header seen this cycle
//   err                 protocol error seen this cycle
module entity_rx_parser
    import entity_loader_pkg::*;
#(
    parameter int NUM_ENTITIES = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          byte_in,
    input  logic                byte_vld,
    output logic                wr_en,
    output logic [SLOT_W-1:0]   wr_slot,
    output logic [ENTITY_W-1:0] wr_data,
    output logic                commit_req,
    output logic                err
);

    localparam logic [SLOT_W:0] NUM_SLOTS = (SLOT_W+1)'(NUM_ENTITIES);

    rx_state_t         state, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [HALF_W-1:0] upper_q, upper_d;

    logic is_hdr, is_commit, slot_ok;

    assign is_hdr    = byte_in[HDR_BIT];
    assign is_commit = byte_in[CMD_COMMIT_BIT];
    assign slot_ok   = {1'b0, slot_q} < NUM_SLOTS;

    // State register; slot/upper are payload and need no reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
        slot_q  <= slot_d;
        upper_q <= upper_d;
    end

    // Next state. A header always restarts framing, whatever the state.
    always_comb begin
        state_d = state;
        slot_d  = slot_q;
        upper_d = upper_q;
        if (byte_vld) begin
            if (is_hdr) begin
                if (is_commit) begin
                    state_d = IDLE;
                end else begin
                    state_d = HI;
                    slot_d  = byte_in[SLOT_W-1:0];
                end
            end else begin
                case (state)
                    IDLE: state_d = IDLE;
                    HI: begin
                        state_d = LO;
                        upper_d = byte_in[HALF_W-1:0];
                    end
                    LO:      state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Outputs. An out-of-range slot is parsed fully and only rejected at
    // the final byte, so the stream stays in step with the sender.
    always_comb begin
        wr_en      = 1'b0;
        err        = 1'b0;
        commit_req = 1'b0;
        wr_slot    = slot_q;
        wr_data    = {upper_q, byte_in[HALF_W-1:0]};
        if (byte_vld) begin
            if (is_hdr) begin
                err        = (state != IDLE);
                commit_req = is_commit;
            end else begin
                case (state)
                    IDLE: err = 1'b1;
                    LO: begin
                        wr_en = slot_ok;
                        err   = !slot_ok;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/entity_loader.sv
// entity_loader
// Receives entity descriptors over a framed byte stream into a shadow bank
// and copies the shadow bank to the active bank on a frame boundary after a
// commit, so the renderer never sees a half-updated scene.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   data_in          stream byte
//   data_valid       byte strobe
//   frame_sync       one-cycle pulse at the frame boundary
//   entities         active bank, slot k at [k*ENTITY_W +: ENTITY_W]
//   commit_pending   commit requested, swap not yet done
//   swap_done        one-cycle pulse the cycle after the swap
//   err              one-cycle pulse after a protocol error
// Macro ENTITY_LOADER_SYNC_EN: when defined, data_in/data_valid pass through
// a 2-flop synchroniser and a byte is taken on the rising edge of the
// synchronised strobe (for direct connection to external pins).
module entity_loader
    import entity_loader_pkg::*;
#(
    parameter int NUM_ENTITIES = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid,
    input  logic                             frame_sync,
    output logic [NUM_ENTITIES*ENTITY_W-1:0] entities,
    output logic                             commit_pending,
    output logic                             swap_done,
    output logic                             err
);

    logic [7:0]          rx_byte;
    logic                rx_vld;
    logic                wr_en, commit_req, rx_err, do_swap;
    logic [SLOT_W-1:0]   wr_slot;
    logic [ENTITY_W-1:0] wr_data;

    logic [ENTITY_W-1:0] shadow [NUM_ENTITIES];
    logic [ENTITY_W-1:0] active [NUM_ENTITIES];

`ifdef ENTITY_LOADER_SYNC_EN
    logic [7:0] data_p0, data_p1;
    logic       vld_p0, vld_p1, vld_p2;

    // Stage p0/p1: metastability flops; p2 holds the previous strobe level
    always_ff @(posedge clk) begin
        data_p0 <= data_in;
        data_p1 <= data_p0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= data_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    assign rx_byte = data_p1;
    assign rx_vld  = vld_p1 & ~vld_p2;
`else
    assign rx_byte = data_in;
    assign rx_vld  = data_valid;
`endif

    entity_rx_parser #(
        .NUM_ENTITIES (NUM_ENTITIES)
    ) u_parser (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (rx_byte),
        .byte_vld   (rx_vld),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .err        (rx_err)
    );

    assign do_swap = frame_sync && commit_pending;

    // Active takes the pre-edge shadow, so a write finishing in the swap
    // cycle lands in shadow only and waits for the next commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ENTITIES; k++) begin
                shadow[k] <= RESET_DESC;
                active[k] <= RESET_DESC;
            end
        end else begin
            for (int k = 0; k < NUM_ENTITIES; k++) begin
                if (do_swap) begin
                    active[k] <= shadow[k];
                end
                if (wr_en && (wr_slot == SLOT_W'(k))) begin
                    shadow[k] <= wr_data;
                end
            end
        end
    end

    // A commit arriving in the swap cycle re-arms pending for the next frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            swap_done      <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (commit_req) begin
                commit_pending <= 1'b1;
            end else if (do_swap) begin
                commit_pending <= 1'b0;
            end
            swap_done <= do_swap;
            err       <= rx_err;
        end
    end

    always_comb begin
        entities = '0;
        for (int k = 0; k < NUM_ENTITIES; k++) begin
            entities[k*ENTITY_W +: ENTITY_W] = active[k];
        end
    end

endmodule
